// File: rtl/udma_l2_port_arbiter.sv
// Merges the uDMA ro/wo L2 channels onto one TCDM-style master port with
// round-robin arbitration and an in-order owner FIFO that steers responses back.
module udma_l2_port_arbiter #(
    parameter int unsigned L2_DATA_WIDTH   = 32,
    parameter int unsigned L2_ADDR_WIDTH   = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                       sys_clk_i,
    input  logic                       sys_rst_ni,

    input  logic                       ro_req_i,
    input  logic                       ro_wen_i,
    input  logic [L2_ADDR_WIDTH-1:0]   ro_addr_i,
    input  logic [L2_DATA_WIDTH/8-1:0] ro_be_i,
    input  logic [L2_DATA_WIDTH-1:0]   ro_wdata_i,
    output logic                       ro_gnt_o,
    output logic                       ro_rvalid_o,
    output logic [L2_DATA_WIDTH-1:0]   ro_rdata_o,

    input  logic                       wo_req_i,
    input  logic                       wo_wen_i,
    input  logic [L2_ADDR_WIDTH-1:0]   wo_addr_i,
    input  logic [L2_DATA_WIDTH/8-1:0] wo_be_i,
    input  logic [L2_DATA_WIDTH-1:0]   wo_wdata_i,
    output logic                       wo_gnt_o,
    output logic                       wo_rvalid_o,
    output logic [L2_DATA_WIDTH-1:0]   wo_rdata_o,

    output logic                       l2_req_o,
    output logic                       l2_wen_o,
    output logic [L2_ADDR_WIDTH-1:0]   l2_addr_o,
    output logic [L2_DATA_WIDTH/8-1:0] l2_be_o,
    output logic [L2_DATA_WIDTH-1:0]   l2_wdata_o,
    input  logic                       l2_gnt_i,
    input  logic                       l2_rvalid_i,
    input  logic [L2_DATA_WIDTH-1:0]   l2_rdata_i,

    output logic                       busy_o,
    output logic                       err_o
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        OWNER_RO = 1'b0,
        OWNER_WO = 1'b1
    } owner_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    owner_e           last_grant_q, last_grant_d;
    logic             err_q, err_d;
    owner_e           owner_q [MAX_OUTSTANDING];
    owner_e           owner_d [MAX_OUTSTANDING];

    logic   fifo_full;
    logic   fifo_empty;
    owner_e sel;
    logic   handshake;
    logic   pop;

    always_comb begin
        fifo_full  = (cnt_q == CNT_FULL);
        fifo_empty = (cnt_q == '0);

        // On a tie the requester that did not win the last handshake goes next.
        if (ro_req_i && wo_req_i) begin
            sel = (last_grant_q == OWNER_RO) ? OWNER_WO : OWNER_RO;
        end else if (wo_req_i) begin
            sel = OWNER_WO;
        end else begin
            sel = OWNER_RO;
        end

        l2_req_o   = ~fifo_full & (ro_req_i | wo_req_i);
        l2_wen_o   = (sel == OWNER_WO) ? wo_wen_i   : ro_wen_i;
        l2_addr_o  = (sel == OWNER_WO) ? wo_addr_i  : ro_addr_i;
        l2_be_o    = (sel == OWNER_WO) ? wo_be_i    : ro_be_i;
        l2_wdata_o = (sel == OWNER_WO) ? wo_wdata_i : ro_wdata_i;

        handshake = l2_req_o & l2_gnt_i;
        ro_gnt_o  = handshake & (sel == OWNER_RO);
        wo_gnt_o  = handshake & (sel == OWNER_WO);

        // A response with nothing outstanding is dropped and flagged, never popped.
        pop         = l2_rvalid_i & ~fifo_empty;
        ro_rvalid_o = pop & (owner_q[rptr_q] == OWNER_RO);
        wo_rvalid_o = pop & (owner_q[rptr_q] == OWNER_WO);
        ro_rdata_o  = l2_rdata_i;
        wo_rdata_o  = l2_rdata_i;

        busy_o = ~fifo_empty;
        err_o  = err_q;
    end

    always_comb begin
        cnt_d        = cnt_q + CNT_W'(handshake) - CNT_W'(pop);
        wptr_d       = handshake ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d       = pop ? rptr_q + PTR_W'(1) : rptr_q;
        last_grant_d = handshake ? sel : last_grant_q;
        err_d        = err_q | (l2_rvalid_i & fifo_empty);
        owner_d      = owner_q;
        if (handshake) begin
            owner_d[wptr_q] = sel;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_ni) begin
            cnt_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            last_grant_q <= OWNER_WO;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    // Owner slots are only read behind a valid count, so they need no reset.
    always_ff @(posedge sys_clk_i) begin
        owner_q <= owner_d;
    end

endmodule

// File: tb/tb_udma_l2_port_arbiter.sv
// Bench for udma_l2_port_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based model of the arbitration and response rules.
module tb_udma_l2_port_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int MAXO = 4;

    logic          clk;
    logic          rst_n;
    logic          ro_req, ro_wen, wo_req, wo_wen;
    logic [AW-1:0] ro_addr, wo_addr;
    logic [DW/8-1:0] ro_be, wo_be;
    logic [DW-1:0] ro_wdata, wo_wdata;
    logic          ro_gnt, ro_rvalid, wo_gnt, wo_rvalid;
    logic [DW-1:0] ro_rdata, wo_rdata;
    logic          l2_req, l2_wen;
    logic [AW-1:0] l2_addr;
    logic [DW/8-1:0] l2_be;
    logic [DW-1:0] l2_wdata;
    logic          l2_gnt, l2_rvalid;
    logic [DW-1:0] l2_rdata;
    logic          busy, err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: outstanding owners in issue order (0 = ro, 1 = wo)
    int q[$];
    bit mlast;
    bit merr;
    bit exp_l2_req, exp_sel_wo, exp_ro_gnt, exp_wo_gnt, exp_ro_rv, exp_wo_rv, exp_busy, exp_err;

    udma_l2_port_arbiter #(
        .L2_DATA_WIDTH  (DW),
        .L2_ADDR_WIDTH  (AW),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .sys_clk_i  (clk),
        .sys_rst_ni (rst_n),
        .ro_req_i   (ro_req),
        .ro_wen_i   (ro_wen),
        .ro_addr_i  (ro_addr),
        .ro_be_i    (ro_be),
        .ro_wdata_i (ro_wdata),
        .ro_gnt_o   (ro_gnt),
        .ro_rvalid_o(ro_rvalid),
        .ro_rdata_o (ro_rdata),
        .wo_req_i   (wo_req),
        .wo_wen_i   (wo_wen),
        .wo_addr_i  (wo_addr),
        .wo_be_i    (wo_be),
        .wo_wdata_i (wo_wdata),
        .wo_gnt_o   (wo_gnt),
        .wo_rvalid_o(wo_rvalid),
        .wo_rdata_o (wo_rdata),
        .l2_req_o   (l2_req),
        .l2_wen_o   (l2_wen),
        .l2_addr_o  (l2_addr),
        .l2_be_o    (l2_be),
        .l2_wdata_o (l2_wdata),
        .l2_gnt_i   (l2_gnt),
        .l2_rvalid_i(l2_rvalid),
        .l2_rdata_i (l2_rdata),
        .busy_o     (busy),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_expect();
        bit full, pop;
        full       = (q.size() >= MAXO);
        exp_sel_wo = (ro_req && wo_req) ? (mlast == 1'b0) : wo_req;
        exp_l2_req = !full && (ro_req || wo_req);
        exp_ro_gnt = exp_l2_req && l2_gnt && !exp_sel_wo;
        exp_wo_gnt = exp_l2_req && l2_gnt && exp_sel_wo;
        pop        = l2_rvalid && (q.size() > 0);
        exp_ro_rv  = pop && (q[0] == 0);
        exp_wo_rv  = pop && (q[0] == 1);
        exp_busy   = (q.size() > 0);
        exp_err    = merr;
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            q.delete();
            mlast = 1'b1;
            merr  = 1'b0;
        end else begin
            if (l2_rvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else merr = 1'b1;
            end
            if (exp_ro_gnt || exp_wo_gnt) begin
                q.push_back(exp_wo_gnt ? 1 : 0);
                mlast = exp_wo_gnt;
            end
        end
    endtask

    task automatic tick();
        model_expect();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        ro_req = 0; ro_wen = 1; ro_addr = '0; ro_be = '1; ro_wdata = '0;
        wo_req = 0; wo_wen = 0; wo_addr = '0; wo_be = '1; wo_wdata = '0;
        l2_gnt = 0; l2_rvalid = 0; l2_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        l2_rdata = 32'h1234_5678;
        #1;
        n_cmp++; if (l2_req !== 1'b0) begin n_fail++; $display("FAIL reset_l2_req got %b exp 0", l2_req); end
        n_cmp++; if ({ro_gnt, wo_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b exp 00", {ro_gnt, wo_gnt}); end
        n_cmp++; if ({ro_rvalid, wo_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b exp 00", {ro_rvalid, wo_rvalid}); end
        n_cmp++; if ({busy, err} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_err got %b exp 00", {busy, err}); end
        n_cmp++; if (ro_rdata !== 32'h1234_5678 || wo_rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL reset_rdata got %h/%h exp 12345678", ro_rdata, wo_rdata); end
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        ro_req = 1; ro_wen = 1; ro_addr = 32'h1C00_0000; l2_gnt = 1;
        #1;
        n_cmp++; if (ro_gnt !== 1'b1 || wo_gnt !== 1'b0) begin n_fail++; $display("FAIL single_gnt got ro=%b wo=%b exp ro=1 wo=0", ro_gnt, wo_gnt); end
        n_cmp++; if (l2_addr !== 32'h1C00_0000 || l2_wen !== 1'b1) begin n_fail++; $display("FAIL single_addr got %h wen=%b exp 1c000000 wen=1", l2_addr, l2_wen); end
        tick();
        ro_req = 0; l2_gnt = 0;
        tick();
        l2_rvalid = 1; l2_rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (ro_rvalid !== 1'b1 || wo_rvalid !== 1'b0) begin n_fail++; $display("FAIL single_rvalid got ro=%b wo=%b exp ro=1 wo=0", ro_rvalid, wo_rvalid); end
        n_cmp++; if (ro_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata got %h exp deadbeef", ro_rdata); end
        tick();
        l2_rvalid = 0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got %b exp 0", busy); end
    endtask

    task automatic test_round_robin();
        do_reset();
        ro_req = 1; wo_req = 1; ro_addr = 32'hA000_0000; wo_addr = 32'hB000_0000; l2_gnt = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (ro_gnt !== (i % 2 == 0) || wo_gnt !== (i % 2 == 1)) begin
                n_fail++; $display("FAIL rr_gnt[%0d] got ro=%b wo=%b exp ro=%0d", i, ro_gnt, wo_gnt, (i % 2 == 0)); end
            n_cmp++; if (l2_addr !== ((i % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000)) begin
                n_fail++; $display("FAIL rr_addr[%0d] got %h", i, l2_addr); end
            tick();
        end
        ro_req = 0; wo_req = 0; l2_gnt = 0; l2_rvalid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (ro_rvalid !== (i % 2 == 0) || wo_rvalid !== (i % 2 == 1)) begin
                n_fail++; $display("FAIL rr_rvalid[%0d] got ro=%b wo=%b exp ro=%0d", i, ro_rvalid, wo_rvalid, (i % 2 == 0)); end
            tick();
        end
        l2_rvalid = 0;
    endtask

    task automatic test_full_stall();
        do_reset();
        ro_req = 1; l2_gnt = 1;
        for (int i = 0; i < MAXO; i++) begin
            #1;
            n_cmp++; if (ro_gnt !== 1'b1) begin n_fail++; $display("FAIL full_fill_gnt[%0d] got %b exp 1", i, ro_gnt); end
            tick();
        end
        #1;
        n_cmp++; if (l2_req !== 1'b0 || ro_gnt !== 1'b0) begin n_fail++; $display("FAIL full_block got req=%b gnt=%b exp 0 0", l2_req, ro_gnt); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy got %b exp 1", busy); end
        l2_rvalid = 1;
        #1;
        n_cmp++; if (ro_rvalid !== 1'b1 || ro_gnt !== 1'b0) begin n_fail++; $display("FAIL full_pop_nobypass got rv=%b gnt=%b exp 1 0", ro_rvalid, ro_gnt); end
        tick();
        l2_rvalid = 0;
        #1;
        n_cmp++; if (ro_gnt !== 1'b1 || l2_req !== 1'b1) begin n_fail++; $display("FAIL full_resume got gnt=%b req=%b exp 1 1", ro_gnt, l2_req); end
        tick();
        ro_req = 0; l2_gnt = 0; l2_rvalid = 1;
        for (int i = 0; i < MAXO; i++) tick();
        l2_rvalid = 0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_drain_busy got %b exp 0", busy); end
    endtask

    task automatic test_simul_push_pop();
        do_reset();
        ro_req = 1; l2_gnt = 1;
        tick();
        tick();
        ro_req = 0; wo_req = 1; l2_rvalid = 1;
        #1;
        n_cmp++; if (wo_gnt !== 1'b1 || ro_rvalid !== 1'b1 || wo_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL simul got wo_gnt=%b ro_rv=%b wo_rv=%b exp 1 1 0", wo_gnt, ro_rvalid, wo_rvalid); end
        tick();
        wo_req = 0; l2_gnt = 0; l2_rvalid = 0;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL simul_busy got %b exp 1", busy); end
        l2_rvalid = 1;
        #1;
        n_cmp++; if (ro_rvalid !== 1'b1 || wo_rvalid !== 1'b0) begin n_fail++; $display("FAIL simul_head got ro=%b wo=%b exp 1 0", ro_rvalid, wo_rvalid); end
        tick();
        #1;
        n_cmp++; if (wo_rvalid !== 1'b1 || ro_rvalid !== 1'b0) begin n_fail++; $display("FAIL simul_tail got ro=%b wo=%b exp 0 1", ro_rvalid, wo_rvalid); end
        tick();
        l2_rvalid = 0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_empty got %b exp 0", busy); end
    endtask

    task automatic test_spurious_err();
        do_reset();
        l2_rvalid = 1;
        #1;
        n_cmp++; if ({ro_rvalid, wo_rvalid} !== 2'b00 || err !== 1'b0) begin
            n_fail++; $display("FAIL spur_same got rv=%b err=%b exp 00 0", {ro_rvalid, wo_rvalid}, err); end
        tick();
        l2_rvalid = 0;
        #1;
        n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL spur_err got err=%b busy=%b exp 1 0", err, busy); end
        tick(); tick(); tick();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_sticky got %b exp 1", err); end
        do_reset();
        #1;
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL spur_clear got %b exp 0", err); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        ro_req = 1; l2_gnt = 1;
        for (int i = 0; i < 3; i++) tick();
        idle_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy); end
        ro_req = 1; wo_req = 1; l2_gnt = 1;
        #1;
        n_cmp++; if (ro_gnt !== 1'b1 || wo_gnt !== 1'b0) begin n_fail++; $display("FAIL midrst_first got ro=%b wo=%b exp 1 0", ro_gnt, wo_gnt); end
        tick();
        idle_inputs();
        l2_rvalid = 1;
        #1;
        n_cmp++; if (ro_rvalid !== 1'b1 || wo_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rv got ro=%b wo=%b exp 1 0", ro_rvalid, wo_rvalid); end
        tick();
        l2_rvalid = 0;
    endtask

    task automatic test_random();
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        logic [DW/8-1:0] eb;
        logic ewen;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            ro_req = ($urandom_range(0, 3) != 0); wo_req = ($urandom_range(0, 3) != 0);
            ro_wen = 1'($urandom); wo_wen = 1'($urandom);
            ro_addr = $urandom; wo_addr = $urandom;
            ro_be = 4'($urandom); wo_be = 4'($urandom);
            ro_wdata = $urandom; wo_wdata = $urandom;
            l2_gnt = ($urandom_range(0, 2) != 0);
            l2_rvalid = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
            l2_rdata = $urandom;
            #1;
            model_expect();
            n_cmp++; if ({l2_req, ro_gnt, wo_gnt} !== {exp_l2_req, exp_ro_gnt, exp_wo_gnt}) begin
                n_fail++; $display("FAIL rnd_req[%0d] got req/rg/wg=%b exp %b", i, {l2_req, ro_gnt, wo_gnt}, {exp_l2_req, exp_ro_gnt, exp_wo_gnt}); end
            n_cmp++; if ({ro_rvalid, wo_rvalid, busy, err} !== {exp_ro_rv, exp_wo_rv, exp_busy, exp_err}) begin
                n_fail++; $display("FAIL rnd_rsp[%0d] got rr/wr/busy/err=%b exp %b", i, {ro_rvalid, wo_rvalid, busy, err}, {exp_ro_rv, exp_wo_rv, exp_busy, exp_err}); end
            n_cmp++; if (ro_rdata !== l2_rdata || wo_rdata !== l2_rdata) begin
                n_fail++; $display("FAIL rnd_rdata[%0d] got %h/%h exp %h", i, ro_rdata, wo_rdata, l2_rdata); end
            if (exp_l2_req) begin
                ea = exp_sel_wo ? wo_addr : ro_addr;
                ew = exp_sel_wo ? wo_wdata : ro_wdata;
                eb = exp_sel_wo ? wo_be : ro_be;
                ewen = exp_sel_wo ? wo_wen : ro_wen;
                n_cmp++; if ({l2_addr, l2_wdata, l2_be, l2_wen} !== {ea, ew, eb, ewen}) begin
                    n_fail++; $display("FAIL rnd_mux[%0d] got %h %h %h %b exp %h %h %h %b", i, l2_addr, l2_wdata, l2_be, l2_wen, ea, ew, eb, ewen); end
            end
            tick();
        end
        idle_inputs();
        l2_rvalid = 1;
        for (int i = 0; i < MAXO + 1; i++) begin
            if (q.size() == 0) l2_rvalid = 0;
            tick();
        end
        l2_rvalid = 0;
        #1;
        n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rnd_final got busy=%b err=%b exp 0 0", busy, err); end
    endtask

    initial begin
        q.delete();
        mlast = 1'b1;
        merr  = 1'b0;
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_full_stall();
        test_simul_push_pop();
        test_spurious_err();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
